regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between the pipeline writeback stage and the late-returning memory/load path. Writeback has priority, and memory returns wait in a small queue. A starvation guard forces a memory grant after a bounded wait. Queued entries made stale by a younger writeback to the same register are squashed. The block drives the register file's write enable, destination and data; R0 stays unwritable.

---
 rtl/regwr_pkg.sv | 20 ++
 rtl/regwr_fifo.sv | 58 +++++
 rtl/regfile_write_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/regwr_pkg.sv
// rtl/regwr_pkg.sv - shared types for the register file write arbiter
package regwr_pkg;

  localparam int REGWR_DATA_W = 16;
  localparam int REGWR_ADDR_W = 4;

  // A dead entry still holds its slot until it reaches the head and is popped.
  typedef struct packed {
    logic                    valid;
    logic                    live;
    logic [REGWR_ADDR_W-1:0] reg_idx;
    logic [REGWR_DATA_W-1:0] data;
  } regwr_entry_t;

  typedef enum logic {
    NORMAL,
    FORCE_MEM
  } regwr_state_e;

endpackage

// File: rtl/regwr_fifo.sv
// rtl/regwr_fifo.sv - circular memory-return queue with per-entry squash against a writeback destination
module regwr_fifo
  import regwr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [REGWR_ADDR_W-1:0] push_reg_i,
  input  logic [REGWR_DATA_W-1:0] push_data_i,
  input  logic                    pop_i,
  input  logic                    squash_en_i,
  input  logic [REGWR_ADDR_W-1:0] squash_reg_i,
  output regwr_entry_t            head_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  regwr_entry_t   slot_q [DEPTH];
  logic [PW-1:0]  rd_q, wr_q;
  logic [CW-1:0]  cnt_q;

  assign head_o  = slot_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en_i && slot_q[i].valid && (slot_q[i].reg_idx == squash_reg_i))
          slot_q[i].live <= 1'b0;
      end
      if (pop_i) begin
        slot_q[rd_q].valid <= 1'b0;
        rd_q               <= rd_q + 1'b1;
      end
      // A same-cycle writeback to this register makes the incoming entry stale on arrival.
      if (push_i) begin
        slot_q[wr_q] <= '{valid:   1'b1,
                          live:    !(squash_en_i && (squash_reg_i == push_reg_i)),
                          reg_idx: push_reg_i,
                          data:    push_data_i};
        wr_q         <= wr_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - single write port shared by writeback and memory returns; starve guard under REGWR_STARVE_GUARD_EN
module regfile_write_arbiter
  import regwr_pkg::*;
#(
  parameter int DATA_W       = REGWR_DATA_W,
  parameter int ADDR_W       = REGWR_ADDR_W,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_reg,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   wb_ready,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_reg,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_reg,
  output logic [DATA_W-1:0]      wr_data,
  output logic [$clog2(DEPTH):0] q_count
);

  regwr_entry_t      head;
  logic              full, push, pop, wb_grant, mem_grant;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_reg_q;
  logic [DATA_W-1:0] wr_data_q;

  assign mem_ready = rst_n && !full;
  assign wb_grant  = wb_valid && wb_ready && (wb_reg != '0);
  assign mem_grant = head.valid && head.live && !wb_grant;
  // Dead heads drain unconditionally; a live head leaves only when it wins the port.
  assign pop       = head.valid && !(head.live && wb_grant);
  assign push      = mem_valid && mem_ready && (mem_reg != '0);

  regwr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_reg_i   (mem_reg),
    .push_data_i  (mem_data),
    .pop_i        (pop),
    .squash_en_i  (wb_grant),
    .squash_reg_i (wb_reg),
    .head_o       (head),
    .full_o       (full),
    .count_o      (q_count)
  );

`ifdef REGWR_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  regwr_state_e  state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;

  assign wb_ready = rst_n && (state_q == NORMAL);

  // In NORMAL a valid head that is not popped is necessarily live and lost to a wb.
  always_comb begin
    state_d  = NORMAL;
    starve_d = '0;
    if ((state_q == NORMAL) && head.valid && !pop) begin
      if (starve_q == SW'(STARVE_LIMIT - 1)) state_d  = FORCE_MEM;
      else                                   starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign wb_ready = rst_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wb_grant || mem_grant;
      if (wb_grant) begin
        wr_reg_q  <= wb_reg;
        wr_data_q <= wb_data;
      end else if (mem_grant) begin
        wr_reg_q  <= head.reg_idx;
        wr_data_q <= head.data;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized bench for regfile_write_arbiter against a queue-level reference model
module tb_regfile_write_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n, wb_valid, mem_valid;
  logic [AW-1:0] wb_reg, mem_reg, wr_reg;
  logic [DW-1:0] wb_data, mem_data, wr_data;
  logic          wb_ready, mem_ready, wr_en;
  logic [CW-1:0] q_count;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .q_count(q_count)
  );

  typedef struct {
    int r;
    int d;
    bit live;
  } ent_t;

  ent_t mq[$];
  bit   m_en;
  int   m_reg, m_data;
`ifdef REGWR_STARVE_GUARD_EN
  int   starve;
  bit   force_m;
`endif
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check readies, advance the model, check the write port after the edge.
  task automatic cyc(input bit rst, input bit wv, input int wr, input int wd,
                     input bit mv, input int mr, input int md);
    bit exp_wbr, exp_memr, wbg, hp, hl, popped;
    rst_n     = !rst;
    wb_valid  = wv;
    wb_reg    = AW'(wr);
    wb_data   = DW'(wd);
    mem_valid = mv;
    mem_reg   = AW'(mr);
    mem_data  = DW'(md);
    #1;
    if (rst) begin
      exp_wbr  = 1'b0;
      exp_memr = 1'b0;
    end else begin
`ifdef REGWR_STARVE_GUARD_EN
      exp_wbr = !force_m;
`else
      exp_wbr = 1'b1;
`endif
      exp_memr = (mq.size() < DEPTH);
    end
    check("wb_ready", 32'(wb_ready), 32'(exp_wbr));
    check("mem_ready", 32'(mem_ready), 32'(exp_memr));

    if (rst) begin
      mq.delete();
      m_en   = 1'b0;
      m_reg  = 0;
      m_data = 0;
`ifdef REGWR_STARVE_GUARD_EN
      starve  = 0;
      force_m = 1'b0;
`endif
    end else begin
      wbg    = wv && exp_wbr && (wr != 0);
      hp     = (mq.size() > 0);
      hl     = hp && mq[0].live;
      popped = 1'b0;
      m_en   = 1'b0;
      if (hp && !hl) begin
        mq.delete(0);
        popped = 1'b1;
      end else if (hl && !wbg) begin
        m_en   = 1'b1;
        m_reg  = mq[0].r;
        m_data = mq[0].d;
        mq.delete(0);
        popped = 1'b1;
      end
      if (wbg) begin
        m_en   = 1'b1;
        m_reg  = wr;
        m_data = wd;
      end
`ifdef REGWR_STARVE_GUARD_EN
      if (force_m) begin
        force_m = 1'b0;
        starve  = 0;
      end else if (!hp || popped) begin
        starve = 0;
      end else if (hl && wbg) begin
        starve++;
        if (starve == LIMIT) begin
          force_m = 1'b1;
          starve  = 0;
        end
      end
`endif
      if (wbg) foreach (mq[i]) if (mq[i].r == wr) mq[i].live = 1'b0;
      if (mv && exp_memr && (mr != 0)) mq.push_back('{r: mr, d: md, live: !(wbg && (wr == mr))});
    end

    @(posedge clk);
    #1;
    check("wr_en", 32'(wr_en), 32'(m_en));
    check("wr_reg", 32'(wr_reg), 32'(m_reg));
    check("wr_data", 32'(wr_data), 32'(m_data));
    check("q_count", 32'(q_count), 32'(mq.size()));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; mem_valid = 1'b0;
    wb_reg = '0; mem_reg = '0; wb_data = '0; mem_data = '0;
    m_en = 1'b0; m_reg = 0; m_data = 0;
`ifdef REGWR_STARVE_GUARD_EN
    starve = 0; force_m = 1'b0;
`endif
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 'h1234, 1, 3, 'h0303);

    cyc(0, 1, 5, 'h1234, 0, 0, 0);
    cyc(0, 1, 0, 'h9999, 0, 0, 0);
    idle(1);

    cyc(0, 0, 0, 0, 1, 3, 'hBEEF);
    idle(2);

    cyc(0, 1, 4, 'h0004, 1, 6, 'h0006);
    cyc(0, 1, 4, 'h0005, 1, 8, 'h0008);
    cyc(0, 1, 4, 'h0006, 1, 9, 'h0009);
    idle(4);

    cyc(0, 1, 1, 'h1111, 1, 7, 'hAAAA);
    cyc(0, 1, 7, 'h5555, 0, 0, 0);
    idle(2);

    cyc(0, 1, 1, 'h0100, 1, 2, 'h2222);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 1, 'h0100 + i, 0, 0, 0);
    idle(2);

    cyc(0, 1, 1, 'h0200, 1, 10, 'h000A);
    cyc(0, 1, 1, 'h0201, 1, 11, 'h000B);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 65535),
          ($urandom_range(0, 1) == 1), $urandom_range(0, 3), $urandom_range(0, 65535));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
